// File: rtl/det_pkg.sv
// Shared widths, FSM state type and the exact 3x3 determinant helper
// for the 5x5 determinant unit.
package det_pkg;

    localparam int unsigned ELEM_W = 8;
    localparam int unsigned OUT_W  = 16;
    localparam int unsigned ACC_W  = 48;
    localparam int unsigned D3_W   = 26;
    localparam int unsigned D4_W   = 36;
    localparam int unsigned TERM_W = 44;
    localparam int unsigned DIM    = 5;
    localparam int unsigned COL_W  = 3;

    typedef logic signed [ELEM_W-1:0] elem_t;

    typedef enum logic {
        IDLE,
        CALC
    } state_e;

    // Exact 3x3 determinant; the final value fits D3_W, so wrapping intermediates are harmless
    function automatic logic signed [D3_W-1:0] det3(
        input elem_t m00, input elem_t m01, input elem_t m02,
        input elem_t m10, input elem_t m11, input elem_t m12,
        input elem_t m20, input elem_t m21, input elem_t m22
    );
        det3 = D3_W'(m00) * (D3_W'(m11) * D3_W'(m22) - D3_W'(m12) * D3_W'(m21))
             - D3_W'(m01) * (D3_W'(m10) * D3_W'(m22) - D3_W'(m12) * D3_W'(m20))
             + D3_W'(m02) * (D3_W'(m10) * D3_W'(m21) - D3_W'(m11) * D3_W'(m20));
    endfunction

endpackage

// File: rtl/det4_comb.sv
// Combinational 4x4 determinant, Laplace expansion along row 0 into 3x3 minors.
module det4_comb
    import det_pkg::*;
(
    input  elem_t                   m_i [16],
    output logic signed [D4_W-1:0]  det_c_o
);

    elem_t                   mn [9];
    logic signed [D4_W-1:0]  cof;

    always_comb begin
        det_c_o = '0;
        mn      = '{default: '0};
        cof     = '0;
        for (int j = 0; j < 4; j++) begin
            for (int r = 1; r < 4; r++) begin
                for (int cc = 0; cc < 3; cc++) begin
                    mn[(r-1)*3 + cc] = m_i[r*4 + ((cc < j) ? cc : cc + 1)];
                end
            end
            cof = D4_W'(m_i[j]) * D4_W'(det3(mn[0], mn[1], mn[2],
                                             mn[3], mn[4], mn[5],
                                             mn[6], mn[7], mn[8]));
            det_c_o = ((j % 2) == 0) ? det_c_o + cof : det_c_o - cof;
        end
    end

endmodule

// File: rtl/det_5x5.sv
// Sequential 5x5 determinant: one row-0 cofactor per cycle, 5-cycle latency,
// low 16 bits of the exact result with a one-cycle done pulse.
module det_5x5
    import det_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  elem_t                    a, b, c, d, e,
    input  elem_t                    f, g, h, i, j,
    input  elem_t                    k, l, m, n, o,
    input  elem_t                    p, q, r, s, t,
    input  elem_t                    u, v, w, x, y,
    output logic signed [OUT_W-1:0]  resultado,
    output logic                     done
);

    state_e                    state_q, state_d;
    logic [COL_W-1:0]          col_q, col_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [OUT_W-1:0]   res_q, res_d;
    logic                      done_q, done_d;
    logic                      load_c;

    elem_t                     m_q  [DIM][DIM];
    elem_t                     m_in [DIM][DIM];
    elem_t                     minor [16];
    logic [COL_W-1:0]          sel;
    logic signed [D4_W-1:0]    det4_c;
    logic signed [TERM_W-1:0]  prod_c, term_c;
    logic signed [ACC_W-1:0]   sum_c;

    always_comb begin
        m_in = '{'{a, b, c, d, e},
                 '{f, g, h, i, j},
                 '{k, l, m, n, o},
                 '{p, q, r, s, t},
                 '{u, v, w, x, y}};
    end

    // Minor of rows 1..4 with the current column removed
    always_comb begin
        minor = '{default: '0};
        sel   = '0;
        for (int rr = 1; rr < 5; rr++) begin
            for (int cc = 0; cc < 4; cc++) begin
                sel = (COL_W'(cc) < col_q) ? COL_W'(cc) : COL_W'(cc + 1);
                minor[(rr-1)*4 + cc] = m_q[rr][sel];
            end
        end
    end

    det4_comb u_det4 (
        .m_i     (minor),
        .det_c_o (det4_c)
    );

    always_comb begin
        prod_c = TERM_W'(m_q[0][col_q]) * TERM_W'(det4_c);
        term_c = col_q[0] ? -prod_c : prod_c;
        sum_c  = acc_q + ACC_W'(term_c);
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        acc_d   = acc_q;
        res_d   = res_q;
        done_d  = 1'b0;
        load_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_c  = 1'b1;
                    acc_d   = '0;
                    col_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = sum_c;
                if (col_q == COL_W'(DIM - 1)) begin
                    res_d   = OUT_W'(sum_c);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            for (int rr = 0; rr < 5; rr++) begin
                for (int cc = 0; cc < 5; cc++) begin
                    m_q[rr][cc] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            done_q  <= done_d;
            if (load_c) begin
                m_q <= m_in;
            end
        end
    end

    assign resultado = res_q;
    assign done      = done_q;

endmodule

// File: tb/tb_det_5x5.sv
// Bench for det_5x5: vector table, random matrices against a permutation-sum
// model, and hand-written sequences for start/reset timing corners.
module tb_det_5x5;

    typedef logic signed [7:0] mat_t [25];
    typedef struct packed { logic [199:0] m; logic [15:0] exp; } vec_t;
    typedef struct packed { logic [15:0] exp; logic [31:0] cyc; } sb_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic signed [7:0] m_in [25];
    logic signed [15:0] resultado;
    logic              done;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] cyc = 0;
    sb_t         sb [$];
    vec_t        tbl [6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    det_5x5 dut (
        .clk(clk), .rst(rst), .start(start),
        .a(m_in[0]),  .b(m_in[1]),  .c(m_in[2]),  .d(m_in[3]),  .e(m_in[4]),
        .f(m_in[5]),  .g(m_in[6]),  .h(m_in[7]),  .i(m_in[8]),  .j(m_in[9]),
        .k(m_in[10]), .l(m_in[11]), .m(m_in[12]), .n(m_in[13]), .o(m_in[14]),
        .p(m_in[15]), .q(m_in[16]), .r(m_in[17]), .s(m_in[18]), .t(m_in[19]),
        .u(m_in[20]), .v(m_in[21]), .w(m_in[22]), .x(m_in[23]), .y(m_in[24]),
        .resultado(resultado), .done(done)
    );

    function automatic mat_t mk(input int vals [25]);
        mat_t rm;
        for (int z = 0; z < 25; z++) rm[z] = 8'(vals[z]);
        return rm;
    endfunction

    function automatic logic [199:0] pack_m(input mat_t mm);
        logic [199:0] bits;
        for (int z = 0; z < 25; z++) bits[z*8 +: 8] = mm[z];
        return bits;
    endfunction

    function automatic mat_t unpack_m(input logic [199:0] bits);
        mat_t rm;
        for (int z = 0; z < 25; z++) rm[z] = bits[z*8 +: 8];
        return rm;
    endfunction

    function automatic mat_t rand_mat(input bit extreme);
        mat_t rm;
        for (int z = 0; z < 25; z++)
            rm[z] = extreme ? (($urandom & 1) != 0 ? 8'sd127 : -8'sd128) : 8'($urandom);
        return rm;
    endfunction

    // Leibniz sum over all 120 permutations; exact in 64 bits
    function automatic logic [15:0] ref_det(input mat_t mm);
        longint sum, prod;
        int     pp [5];
        int     inv;
        sum = 0;
        for (int p0 = 0; p0 < 5; p0++)
        for (int p1 = 0; p1 < 5; p1++)
        for (int p2 = 0; p2 < 5; p2++)
        for (int p3 = 0; p3 < 5; p3++)
        for (int p4 = 0; p4 < 5; p4++) begin
            if (((1 << p0) | (1 << p1) | (1 << p2) | (1 << p3) | (1 << p4)) == 31) begin
                pp = '{p0, p1, p2, p3, p4};
                inv = 0;
                for (int x1 = 0; x1 < 5; x1++)
                    for (int x2 = x1 + 1; x2 < 5; x2++)
                        if (pp[x1] > pp[x2]) inv++;
                prod = 1;
                for (int rr = 0; rr < 5; rr++) prod = prod * longint'(mm[rr*5 + pp[rr]]);
                sum = (inv % 2 == 1) ? sum - prod : sum + prod;
            end
        end
        return sum[15:0];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        sb_t ent;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0 (t=%0t)", $time);
                end else begin
                    ent = sb.pop_front();
                    check("result", resultado, ent.exp);
                    check("latency", 16'(cyc - ent.cyc), 16'd5);
                end
            end
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge after the capture edge
    task automatic start_now(input mat_t mm, input logic [15:0] exp);
        m_in  = mm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sb.push_back('{exp: exp, cyc: cyc});
    endtask

    // Scramble inputs every cycle while waiting, so only latched values can matter
    task automatic wait_drain();
        for (int nn = 0; nn < 20 && sb.size() != 0; nn++) begin
            @(negedge clk);
            m_in = rand_mat(1'b0);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_mat(input mat_t mm, input logic [15:0] exp);
        @(negedge clk);
        start_now(mm, exp);
        wait_drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        mat_t tm, m2;
        int   vals [25];
        logic [15:0] e;

        rst   = 1'b1;
        start = 1'b0;
        m_in  = '{default: '0};
        fork monitor(); join_none

        // Vector table
        vals = '{default: 0};
        vals[0] = 1; vals[6] = 1; vals[12] = 1; vals[18] = 1; vals[24] = 1;
        tbl[0] = '{m: pack_m(mk(vals)), exp: 16'd1};
        vals = '{1,2,2,2,1, 2,1,2,2,1, 1,2,3,1,2, 2,2,1,2,1, 2,1,1,1,2};
        m2 = mk(vals);
        tbl[1] = '{m: pack_m(m2), exp: 16'd6};
        vals = '{1,2,2,2,1, 2,1,2,2,1, 1,2,2,2,1, 2,2,1,2,1, 2,1,1,1,2};
        tbl[2] = '{m: pack_m(mk(vals)), exp: 16'd0};
        vals = '{2,1,2,2,1, 1,2,2,2,1, 1,2,3,1,2, 2,2,1,2,1, 2,1,1,1,2};
        tbl[3] = '{m: pack_m(mk(vals)), exp: 16'hFFFA};
        vals = '{default: 0};
        vals[0] = 127; vals[6] = 127; vals[12] = 2; vals[18] = 1; vals[24] = 1;
        tbl[4] = '{m: pack_m(mk(vals)), exp: 16'd32258};
        vals[12] = 127;
        tbl[5] = '{m: pack_m(mk(vals)), exp: 16'h417F};

        repeat (2) @(negedge clk);
        check("reset_result", resultado, 16'd0);
        check("reset_done", {15'd0, done}, 16'd0);
        rst = 1'b0;

        for (int vi = 0; vi < 6; vi++) run_mat(unpack_m(tbl[vi].m), tbl[vi].exp);

        // start pulses during CALC are ignored
        @(negedge clk);
        start_now(m2, 16'd6);
        m_in = rand_mat(1'b0); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_drain();
        repeat (8) @(negedge clk);
        check("hold_after_ignored_start", resultado, 16'd6);

        // start in the done cycle gives a second result 5 cycles later
        @(negedge clk);
        start_now(unpack_m(tbl[0].m), 16'd1);
        repeat (5) @(negedge clk);
        start_now(unpack_m(tbl[3].m), 16'hFFFA);
        wait_drain();

        // start held high restarts on every return to IDLE
        @(negedge clk);
        m_in = unpack_m(tbl[5].m); start = 1'b1;
        @(negedge clk);
        sb.push_back('{exp: 16'h417F, cyc: cyc});
        repeat (6) @(negedge clk);
        sb.push_back('{exp: 16'h417F, cyc: cyc});
        repeat (4) @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (8) @(negedge clk);

        // reset in CALC cycle 3 aborts without done and clears the result
        @(negedge clk);
        start_now(m2, 16'd6);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        sb.delete();
        check("abort_result", resultado, 16'd0);
        check("abort_done", {15'd0, done}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_result_hold", resultado, 16'd0);

        // Random and extreme-valued matrices against the model
        for (int ri = 0; ri < 30; ri++) begin
            tm = rand_mat(ri >= 24);
            e  = ref_det(tm);
            run_mat(tm, e);
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
